mux_n_pipe: RTL and testbench

Parametrised N-input, WIDTH-bit select stage with a one-entry registered output and valid/ready handshaking on every input and on the output. It generalises the plain 2:1 combinational data mux into a pipelined selector for the RISC-V datapath, e.g. writeback-source selection or merging multiple request sources onto one bus. Two modes are supported: explicit select, where the source index comes from control, and round-robin arbitration among valid sources.

---
 rtl/mux_n_pipe.sv | 109 ++++++++++
 tb/tb_mux_n_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// N-input, WIDTH-bit valid/ready selector with a single registered output entry.
// MODE 0 picks the channel named by sel; MODE 1 arbitrates round-robin among valid channels.
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N),
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
);

  logic [WIDTH-1:0] out_data_d, out_data_q;
  logic             out_valid_d, out_valid_q;
  logic [SELW-1:0]  out_src_d, out_src_q;
  logic [SELW-1:0]  ptr_d, ptr_q;

  logic [N-1:0]     match_s;
  logic             grant_vld_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [WIDTH-1:0] grant_data_s;
  logic             can_accept_s;
  logic             xfer_s;
  logic [N-1:0]     in_ready_s;

  // Grant selection: explicit index or first valid channel at/after the pointer
  always_comb begin
    match_s     = '0;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    if (MODE == 0) begin
      // Out-of-range sel matches no channel, so it can never grant
      for (int i = 0; i < N; i++) begin
        match_s[i] = (sel == SELW'(i)) & in_valid[i];
      end
      grant_vld_s = |match_s;
      grant_idx_s = sel;
    end else begin
      // Walk offsets from farthest to nearest so the nearest valid channel wins
      for (int off = N - 1; off >= 0; off--) begin
        match_s[off] = in_valid[(int'(ptr_q) + off) % N];
        grant_idx_s  = match_s[off] ? SELW'((int'(ptr_q) + off) % N) : grant_idx_s;
      end
      grant_vld_s = |match_s;
    end
  end

  // Handshake: only the granted channel sees ready, and never while in reset
  always_comb begin
    can_accept_s = ~out_valid_q | out_ready;
    xfer_s       = grant_vld_s & can_accept_s & ~reset;
    grant_data_s = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_s[i] = xfer_s & (grant_idx_s == SELW'(i));
      grant_data_s  = (grant_idx_s == SELW'(i)) ? in_data[i*WIDTH +: WIDTH] : grant_data_s;
    end
  end

  // Next state of the output entry and the round-robin pointer
  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_data_d  = grant_data_s;
      out_src_d   = grant_idx_s;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = (grant_idx_s == SELW'(N - 1)) ? '0 : grant_idx_s + SELW'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: explicit-select (N=4 and N=5) and round-robin (N=4) builds.
module tb_mux_n_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4*W-1:0] in_data;
  logic [3:0]     in_valid0, in_ready0, in_valid1, in_ready1;
  logic [1:0]     sel0, sel1, out_src0, out_src1;
  logic [W-1:0]   out_data0, out_data1, out_data5;
  logic           out_valid0, out_valid1, out_valid5, out_ready0, out_ready1, out_ready5;
  logic [5*W-1:0] in_data5;
  logic [4:0]     in_valid5, in_ready5;
  logic [2:0]     sel5, out_src5;

  mux_n_pipe #(.WIDTH(W), .N(4), .MODE(0)) d0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid0), .in_ready(in_ready0),
    .sel(sel0), .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_src(out_src0));
  mux_n_pipe #(.WIDTH(W), .N(4), .MODE(1)) d1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1), .in_ready(in_ready1),
    .sel(sel1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_src(out_src1));
  mux_n_pipe #(.WIDTH(W), .N(5), .SELW(3), .MODE(0)) d5 (
    .clk(clk), .reset(reset), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .sel(sel5), .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5), .out_src(out_src5));

  typedef struct {
    logic [W-1:0] data;
    logic [2:0]   src;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   m_ov0, m_ov1;
  int   m_ptr;
  logic [3:0] r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the explicit-select build: predicts in_ready and queues the transfer
  task automatic model0(output logic [3:0] rdy);
    exp_t x;
    rdy = 4'b0000;
    if (reset) begin
      m_ov0 = 1'b0;
    end else if ((!m_ov0 || out_ready0) && in_valid0[sel0]) begin
      rdy[sel0] = 1'b1;
      x.data = in_data[sel0*W +: W];
      x.src  = {1'b0, sel0};
      q0.push_back(x);
      m_ov0 = 1'b1;
    end else if (out_ready0) begin
      m_ov0 = 1'b0;
    end
  endtask

  // Reference model for the round-robin build
  task automatic model1(output logic [3:0] rdy);
    exp_t x;
    int g;
    rdy = 4'b0000;
    g = -1;
    for (int off = 3; off >= 0; off--) begin
      if (in_valid1[(m_ptr + off) % 4]) g = (m_ptr + off) % 4;
    end
    if (reset) begin
      m_ov1 = 1'b0;
      m_ptr = 0;
    end else if ((!m_ov1 || out_ready1) && g >= 0) begin
      rdy[g] = 1'b1;
      x.data = in_data[g*W +: W];
      x.src  = 3'(g);
      q1.push_back(x);
      m_ov1 = 1'b1;
      m_ptr = (g == 3) ? 0 : g + 1;
    end else if (out_ready1) begin
      m_ov1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_ov0 = 1'b0; m_ov1 = 1'b0; m_ptr = 0;
    repeat (2) begin
      tick();
      n_tests++;
      if ({out_valid0, out_data0, out_src0, in_ready0} !== 39'd0) begin
        n_fail++;
        $display("FAIL reset_d0: v=%b d=%h s=%0d rdy=%b, want all zero", out_valid0, out_data0, out_src0, in_ready0);
      end
      n_tests++;
      if ({out_valid1, out_data1, out_src1, in_ready1, out_valid5, in_ready5} !== 45'd0) begin
        n_fail++;
        $display("FAIL reset_d1_d5: v1=%b d1=%h s1=%0d rdy1=%b v5=%b rdy5=%b, want all zero",
                 out_valid1, out_data1, out_src1, in_ready1, out_valid5, in_ready5);
      end
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready1 !== 4'b0001) begin
      n_fail++;
      $display("FAIL rr_first_grant: in_ready=%b want 0001", in_ready1);
    end
    in_valid0 = 4'b0000; in_valid1 = 4'b0000; in_valid5 = 5'b00000;
    tick();
  endtask

  task automatic test_mode0_select();
    logic [1:0] sels[4]   = '{2'd2, 2'd0, 2'd3, 2'd1};
    logic [3:0] valids[4] = '{4'b1111, 4'b1111, 4'b1111, 4'b1101};
    in_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    out_ready0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel0 = sels[k]; in_valid0 = valids[k];
      #1;
      model0(r);
      n_tests++;
      if (in_ready0 !== r) begin
        n_fail++;
        $display("FAIL sel_ready[%0d]: in_ready=%b want %b", k, in_ready0, r);
      end
      tick();
      n_tests++;
      if (q0.size() != 0) begin
        e = q0.pop_front();
        if (out_valid0 !== 1'b1 || out_data0 !== e.data || out_src0 !== e.src[1:0]) begin
          n_fail++;
          $display("FAIL sel_out[%0d]: v=%b d=%h s=%0d want v=1 d=%h s=%0d", k, out_valid0, out_data0, out_src0, e.data, e.src);
        end
      end else if (out_valid0 !== m_ov0) begin
        n_fail++;
        $display("FAIL sel_idle[%0d]: v=%b want %b", k, out_valid0, m_ov0);
      end
    end
    in_valid0 = 4'b0000;
  endtask

  task automatic test_out_of_range();
    int s_tab[4] = '{7, 5, 6, 4};
    for (int i = 0; i < 5; i++) in_data5[i*W +: W] = 32'hE0E00000 + 32'(i);
    in_valid5 = 5'b11111; out_ready5 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel5 = 3'(s_tab[k]);
      #1;
      n_tests++;
      if (in_ready5 !== ((s_tab[k] < 5) ? (5'b00001 << s_tab[k]) : 5'b00000)) begin
        n_fail++;
        $display("FAIL oor_ready sel=%0d: in_ready=%b", s_tab[k], in_ready5);
      end
      tick();
      n_tests++;
      if (s_tab[k] >= 5 && out_valid5 !== 1'b0) begin
        n_fail++;
        $display("FAIL oor_out sel=%0d: v=%b want 0", s_tab[k], out_valid5);
      end else if (s_tab[k] < 5 && (out_valid5 !== 1'b1 || out_src5 !== 3'd4 || out_data5 !== 32'hE0E00004)) begin
        n_fail++;
        $display("FAIL oor_edge sel=4: v=%b s=%0d d=%h want v=1 s=4 d=e0e00004", out_valid5, out_src5, out_data5);
      end
    end
    in_valid5 = 5'b00000;
    tick();
  endtask

  task automatic test_backpressure();
    in_data[1*W +: W] = 32'h12345678;
    sel0 = 2'd1; in_valid0 = 4'b0010; out_ready0 = 1'b1;
    #1;
    model0(r);
    tick();
    e = q0.pop_front();
    n_tests++;
    if (out_valid0 !== 1'b1 || out_data0 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL bp_load: v=%b d=%h want v=1 d=12345678", out_valid0, out_data0);
    end
    out_ready0 = 1'b0;
    in_data[1*W +: W] = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      #1;
      model0(r);
      n_tests++;
      if (in_ready0 !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_ready[%0d]: in_ready=%b want 0000", k, in_ready0);
      end
      tick();
      n_tests++;
      if (out_valid0 !== 1'b1 || out_data0 !== 32'h12345678 || out_src0 !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h s=%0d want v=1 d=12345678 s=1", k, out_valid0, out_data0, out_src0);
      end
    end
    out_ready0 = 1'b1;
    // release followed by back-to-back transfers: every cycle must deliver a new word
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        sel0 = 2'(k - 1); in_valid0 = 4'b1111;
        in_data[(k-1)*W +: W] = 32'h50000000 + 32'(k);
      end
      #1;
      model0(r);
      n_tests++;
      if (in_ready0 !== r) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: in_ready=%b want %b", k, in_ready0, r);
      end
      tick();
      n_tests++;
      e = q0.pop_front();
      if (out_valid0 !== 1'b1 || out_data0 !== e.data || out_src0 !== e.src[1:0]) begin
        n_fail++;
        $display("FAIL b2b_out[%0d]: v=%b d=%h s=%0d want v=1 d=%h s=%0d", k, out_valid0, out_data0, out_src0, e.data, e.src);
      end
    end
    in_valid0 = 4'b0000;
    #1;
    model0(r);
    tick();
    n_tests++;
    if (out_valid0 !== 1'b0 || out_data0 !== e.data || out_src0 !== 2'd3) begin
      n_fail++;
      $display("FAIL drain: v=%b d=%h s=%0d want v=0 d=%h s=3", out_valid0, out_data0, out_src0, e.data);
    end
  endtask

  task automatic run_rr(input string name, input logic [3:0] valid, input int cycles, input int exp_src[8]);
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = 32'hA0A00000 + 32'(i);
    in_valid1 = valid; out_ready1 = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      #1;
      model1(r);
      n_tests++;
      if (in_ready1 !== r) begin
        n_fail++;
        $display("FAIL %s_ready[%0d]: in_ready=%b want %b", name, k, in_ready1, r);
      end
      tick();
      n_tests++;
      e = q1.pop_front();
      if (out_valid1 !== 1'b1 || out_data1 !== e.data || out_src1 !== e.src[1:0] || int'(out_src1) != exp_src[k]) begin
        n_fail++;
        $display("FAIL %s_out[%0d]: v=%b d=%h s=%0d want v=1 d=%h s=%0d", name, k, out_valid1, out_data1, out_src1, e.data, exp_src[k]);
      end
    end
    in_valid1 = 4'b0000;
    #1;
    model1(r);
    tick();
  endtask

  task automatic test_rr_fairness();
    run_rr("rr_fair", 4'b1111, 8, '{0, 1, 2, 3, 0, 1, 2, 3});
  endtask

  task automatic test_rr_skip_wrap();
    run_rr("rr_skip", 4'b1010, 4, '{1, 3, 1, 3, 0, 0, 0, 0});
  endtask

  task automatic test_reset_mid();
    // stalled entry discarded by reset
    in_data[0 +: W] = 32'h0BADF00D;
    sel0 = 2'd0; in_valid0 = 4'b0001; out_ready0 = 1'b1;
    #1;
    model0(r);
    tick();
    e = q0.pop_front();
    in_valid0 = 4'b0000; out_ready0 = 1'b0;
    #1;
    model0(r);
    tick();
    reset = 1'b1;
    in_valid0 = 4'b0001;
    #1;
    model0(r);
    model1(r);
    n_tests++;
    if (in_ready0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_stall_ready: in_ready=%b want 0000", in_ready0);
    end
    tick();
    reset = 1'b0;
    in_valid0 = 4'b0000;
    n_tests++;
    if (out_valid0 !== 1'b0 || out_data0 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_stall: v=%b d=%h want v=0 d=0", out_valid0, out_data0);
    end
    // pointer parked at 2, then reset with every channel valid
    in_valid1 = 4'b0010; out_ready1 = 1'b1;
    #1;
    model1(r);
    tick();
    e = q1.pop_front();
    reset = 1'b1; in_valid1 = 4'b1111;
    #1;
    model1(r);
    tick();
    reset = 1'b0;
    n_tests++;
    if (out_valid1 !== 1'b0 || out_src1 !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_ptr_out: v=%b s=%0d want v=0 s=0", out_valid1, out_src1);
    end
    #1;
    model1(r);
    n_tests++;
    if (in_ready1 !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_ptr_grant: in_ready=%b want 0001", in_ready1);
    end
    tick();
    e = q1.pop_front();
    n_tests++;
    if (out_valid1 !== 1'b1 || out_src1 !== 2'd0 || out_data1 !== e.data) begin
      n_fail++;
      $display("FAIL rst_ptr_first: v=%b s=%0d d=%h want v=1 s=0 d=%h", out_valid1, out_src1, out_data1, e.data);
    end
    in_valid1 = 4'b0000;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    in_data = '0; in_data5 = '0;
    in_valid0 = 4'b1111; in_valid1 = 4'b1111; in_valid5 = 5'b11111;
    sel0 = 2'd0; sel1 = 2'd0; sel5 = 3'd0;
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready5 = 1'b1;
    test_reset();
    test_mode0_select();
    test_out_of_range();
    test_backpressure();
    test_rr_fairness();
    test_rr_skip_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
